// File: rtl/jclock_stepper.sv
// Four-phase clock generator with one-hot stepper and HALT/STEP/RUN control.
// Define JCLK_BREAK_EN to enable the stepper-index breakpoint (brk_step port).
module jclock_stepper #(
  parameter  int DIV    = 2,
  parameter  int NSTEPS = 6,
  parameter  int CW     = 16,
  localparam int SW     = $clog2(NSTEPS)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              step_req,
  input  logic              step_rst,
`ifdef JCLK_BREAK_EN
  input  logic [SW-1:0]     brk_step,
`endif
  output logic              clk,
  output logic              clkd,
  output logic              clke,
  output logic              clks,
  output logic [NSTEPS-1:0] step_out,
  output logic [SW-1:0]     step_idx,
  output logic [CW-1:0]     cyc_cnt,
  output logic              busy,
  output logic              brk_hit
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [1:0] M_STEP = 2'd1;
  localparam logic [1:0] M_RUN  = 2'd2;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} ph_t;

  ph_t           ph, ph_n;
  logic [PW-1:0] presc;
  logic          tick, start, cyc_end;
  logic          step_pend, rst_pend;
  logic          last_step;

  assign tick      = (presc == PW'(DIV - 1));
  assign busy      = (ph != PH3);
  assign last_step = (step_idx == SW'(NSTEPS - 1));
  assign clke      = clk | clkd;
  assign clks      = clk & clkd;
  assign step_out  = {{(NSTEPS-1){1'b0}}, 1'b1} << step_idx;

  always_ff @(posedge CLK) begin
    if (reset) ph <= PH3;
    else       ph <= ph_n;
  end

  // A started cycle always runs to PH3; mode only gates the PH3 -> PH0 start.
  always_comb begin
    ph_n    = ph;
    start   = 1'b0;
    cyc_end = 1'b0;
    if (tick) begin
      case (ph)
        PH0: ph_n = PH1;
        PH1: ph_n = PH2;
        PH2: begin
          ph_n    = PH3;
          cyc_end = 1'b1;
        end
        default: begin
          if ((mode == M_RUN && !brk_hit) || (mode == M_STEP && step_pend)) begin
            start = 1'b1;
            ph_n  = PH0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      presc     <= '0;
      clk       <= 1'b0;
      clkd      <= 1'b0;
      step_idx  <= '0;
      cyc_cnt   <= '0;
      step_pend <= 1'b0;
      rst_pend  <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      clk   <= (ph_n == PH0) || (ph_n == PH1);
      clkd  <= (ph_n == PH1) || (ph_n == PH2);

      // Starting consumes the request; extra requests before the start coalesce.
      if (mode != M_STEP || start) step_pend <= 1'b0;
      else if (step_req)           step_pend <= 1'b1;

      if (cyc_end)               rst_pend <= 1'b0;
      else if (busy && step_rst) rst_pend <= 1'b1;

      if (cyc_end) begin
        cyc_cnt  <= cyc_cnt + CW'(1);
        step_idx <= (rst_pend || step_rst || last_step) ? '0 : step_idx + SW'(1);
      end else if (!busy && step_rst) begin
        step_idx <= '0;
      end
    end
  end

`ifdef JCLK_BREAK_EN
  always_ff @(posedge CLK) begin
    if (reset || mode != M_RUN)              brk_hit <= 1'b0;
    else if (cyc_end && step_idx == brk_step) brk_hit <= 1'b1;
  end
`else
  assign brk_hit = 1'b0;
`endif

endmodule

// File: tb/tb_jclock_stepper.sv
// Bench for jclock_stepper: hand-derived vector table, waveform/breakpoint sequences,
// and randomized stimulus checked every CLK against a behavioural model.
module tb_jclock_stepper;
  localparam int DIV = 2, NSTEPS = 6, CW = 16, SW = $clog2(NSTEPS);
  localparam int VW = 4 + NSTEPS + SW + CW + 2;

  logic CLK = 1'b0, reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic step_req = 1'b0, step_rst = 1'b0;
  logic [SW-1:0] brk_step = '0;
  logic clk, clkd, clke, clks, busy, brk_hit;
  logic [NSTEPS-1:0] step_out;
  logic [SW-1:0] step_idx;
  logic [CW-1:0] cyc_cnt;

  int total = 0, bad = 0;

  always #5 CLK = ~CLK;

  jclock_stepper #(.DIV(DIV), .NSTEPS(NSTEPS), .CW(CW)) dut (
    .CLK(CLK), .reset(reset), .mode(mode), .step_req(step_req), .step_rst(step_rst),
`ifdef JCLK_BREAK_EN
    .brk_step(brk_step),
`endif
    .clk(clk), .clkd(clkd), .clke(clke), .clks(clks), .step_out(step_out),
    .step_idx(step_idx), .cyc_cnt(cyc_cnt), .busy(busy), .brk_hit(brk_hit)
  );

  // Model: quarter index q (0..3 within a cycle, 3 = parked), CLK count within the quarter.
  int m_sub, m_q, m_idx, m_cnt;
  bit m_pend, m_rpend, m_brk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [NSTEPS-1:0] one;
    bit c, cd;
    one = 1;
    c  = (m_q == 0) || (m_q == 1);
    cd = (m_q == 1) || (m_q == 2);
    return {c, cd, c | cd, c & cd, one << m_idx, SW'(m_idx), CW'(m_cnt), m_q != 3, m_brk};
  endfunction

  // Advance one CLK: evaluate the rules on the pre-edge inputs, then compare everything.
  task automatic clk_step();
    bit boundary, fin, go, idle;
    int n_sub, n_q, n_idx, n_cnt;
    bit n_pend, n_rpend, n_brk;
    boundary = (m_sub == DIV - 1);
    idle     = (m_q == 3);
    fin      = boundary && m_q == 2;
    go       = boundary && idle && ((mode == 2 && !m_brk) || (mode == 1 && m_pend));
    n_sub    = boundary ? 0 : m_sub + 1;
    n_q      = !boundary ? m_q : (idle ? (go ? 0 : 3) : m_q + 1);
    n_pend   = (mode == 1) && !go && (m_pend || step_req);
    n_rpend  = fin ? 1'b0 : (m_rpend || (!idle && step_rst));
    n_cnt    = fin ? (m_cnt + 1) % (1 << CW) : m_cnt;
    n_idx    = m_idx;
    if (fin) n_idx = (m_rpend || step_rst) ? 0 : (m_idx + 1) % NSTEPS;
    else if (idle && step_rst) n_idx = 0;
    n_brk = 1'b0;
`ifdef JCLK_BREAK_EN
    if (mode == 2) n_brk = m_brk || (fin && m_idx == int'(brk_step));
`endif
    @(posedge CLK);
    #1;
    if (reset) begin
      m_sub = 0; m_q = 3; m_idx = 0; m_cnt = 0; m_pend = 0; m_rpend = 0; m_brk = 0;
    end else begin
      m_sub = n_sub; m_q = n_q; m_idx = n_idx; m_cnt = n_cnt;
      m_pend = n_pend; m_rpend = n_rpend; m_brk = n_brk;
    end
    chk("model", {clk, clkd, clke, clks, step_out, step_idx, cyc_cnt, busy, brk_hit}, model_vec());
  endtask

  task automatic do_reset();
    reset = 1'b1; mode = 2'd0; step_req = 1'b0; step_rst = 1'b0;
    repeat (3) clk_step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       req;
    logic       rst;
    int         nclk;
    int         idx;
    int         cnt;
    logic       busy;
  } vec_t;

  vec_t vt[15];
  logic [3:0] wave[8];
  int exp3[7];

  initial begin
    logic [NSTEPS-1:0] one;
    bit found, pb;
    int ends;
    one = 1;
    wave = '{4'b1010, 4'b1010, 4'b1111, 4'b1111, 4'b0110, 4'b0110, 4'b0000, 4'b0000};
    exp3 = '{1, 2, 3, 4, 5, 0, 1};
    // Sequential from reset (DIV=2: phase boundaries on odd CLKs after release).
    vt = '{
      '{2'd0, 1'b0, 1'b0, 4, 0, 0, 1'b0},   // HALT: parked
      '{2'd1, 1'b1, 1'b0, 1, 0, 0, 1'b0},   // STEP request latched
      '{2'd1, 1'b1, 1'b0, 1, 0, 0, 1'b1},   // second request; cycle starts
      '{2'd1, 1'b0, 1'b0, 7, 1, 1, 1'b0},   // one cycle only
      '{2'd1, 1'b0, 1'b0, 8, 1, 1, 1'b0},   // no second cycle
      '{2'd2, 1'b0, 1'b0, 1, 1, 1, 1'b1},   // RUN starts
      '{2'd2, 1'b0, 1'b0, 2, 1, 1, 1'b1},   // now at ph1
      '{2'd0, 1'b0, 1'b1, 1, 1, 1, 1'b1},   // HALT + step_rst while busy
      '{2'd0, 1'b0, 1'b0, 6, 0, 2, 1'b0},   // completes, idx reset at end
      '{2'd2, 1'b0, 1'b0, 1, 0, 2, 1'b1},   // RUN starts
      '{2'd0, 1'b0, 1'b0, 7, 1, 3, 1'b0},   // HALT mid-cycle, completes once
      '{2'd0, 1'b0, 1'b1, 1, 0, 3, 1'b0},   // idle step_rst
      '{2'd3, 1'b1, 1'b0, 4, 0, 3, 1'b0},   // mode 3 acts as HALT
      '{2'd1, 1'b1, 1'b0, 1, 0, 3, 1'b0},   // STEP request
      '{2'd1, 1'b0, 1'b0, 8, 1, 4, 1'b0}    // one stepped cycle
    };
    brk_step = SW'(5);

    do_reset();
    chk("reset_clocks", {clk, clkd, clke, clks}, 4'b0000);
    chk("reset_step_out", step_out, 6'b000001);
    chk("reset_cyc_cnt", cyc_cnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_brk", brk_hit, 0);

    // Waveform: 10,11,01,00 each held 2 CLK, 8 CLK period.
    mode = 2'd2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      clk_step();
      if (clk) found = 1;
    end
    chk("wave_start", found, 1);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) clk_step();
      chk($sformatf("wave[%0d]", i), {clk, clkd, clke, clks}, wave[i % 8]);
    end

    // Seven RUN cycles: stepper index at each cycle end.
    do_reset();
    mode = 2'd2;
    ends = 0;
    for (int i = 0; i < 100 && ends < 7; i++) begin
      pb = busy;
      clk_step();
      if (pb && !busy) begin
        chk($sformatf("run_idx[%0d]", ends), step_idx, exp3[ends]);
        ends++;
        if (ends == 7) mode = 2'd0;
      end
    end
    chk("run_ends", ends, 7);
    chk("run_cyc_cnt", cyc_cnt, 7);

    // Vector table.
    do_reset();
    for (int r = 0; r < 15; r++) begin
      mode = vt[r].mode; step_req = vt[r].req; step_rst = vt[r].rst;
      repeat (vt[r].nclk) clk_step();
      chk($sformatf("vec%0d_idx", r), step_idx, vt[r].idx);
      chk($sformatf("vec%0d_cnt", r), cyc_cnt, vt[r].cnt);
      chk($sformatf("vec%0d_busy", r), busy, vt[r].busy);
      chk($sformatf("vec%0d_onehot", r), step_out, one << vt[r].idx);
    end
    step_req = 1'b0; step_rst = 1'b0;

`ifdef JCLK_BREAK_EN
    do_reset();
    brk_step = SW'(3);
    mode = 2'd2;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      clk_step();
      if (brk_hit) found = 1;
    end
    chk("brk_seen", found, 1);
    repeat (4) clk_step();
    chk("brk_idx", step_idx, 4);
    chk("brk_cnt", cyc_cnt, 4);
    chk("brk_busy", busy, 0);
    chk("brk_hold", brk_hit, 1);
    mode = 2'd0;
    clk_step();
    chk("brk_clear", brk_hit, 0);
`endif

    // Randomized run against the model (checked inside clk_step).
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      step_req = ($urandom_range(0, 7) == 0);
      step_rst = ($urandom_range(0, 23) == 0);
      reset    = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) == 0) brk_step = SW'($urandom_range(0, NSTEPS - 1));
      clk_step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
